load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/load_align.sv | 34 +++
 rtl/load_store_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size encodings, FSM states and access classification helpers
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_NONE = 2'b00,
        SIZE_BYTE = 2'b01,
        SIZE_HALF = 2'b10,
        SIZE_WORD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS_LO,
        ACCESS_HI,
        STORE_BYTE,
        RESP
    } state_t;

    // Aligned means the memory lane shifter can do the access in one beat.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_HALF: return ~offset[0];
            SIZE_WORD: return offset == 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_HALF: return offset == 2'b11;
            SIZE_WORD: return offset != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] last_byte(input logic [1:0] size);
        case (size)
            SIZE_HALF: return 2'd1;
            SIZE_WORD: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and extends load data from a {hi, lo} word pair
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [23:0] hi,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        unsigned_load,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // The top byte of the high word can never reach the result, so hi is only 24 bits.
    always_comb begin
        case (offset)
            2'd0:    shifted = lo;
            2'd1:    shifted = {hi[7:0],  lo[31:8]};
            2'd2:    shifted = {hi[15:0], lo[31:16]};
            default: shifted = {hi[23:0], lo[31:24]};
        endcase
    end

    always_comb begin
        case (size)
            SIZE_BYTE: data = {{24{~unsigned_load & shifted[7]}},  shifted[7:0]};
            SIZE_HALF: data = {{16{~unsigned_load & shifted[15]}}, shifted[15:0]};
            SIZE_WORD: data = shifted;
            default:   data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit splitting misaligned accesses
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    output logic [31:0]              resp_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [1:0]               mem_write_enable,
    output logic [31:0]              mem_write_value,
    input  logic [31:0]              mem_read_value
);
    import lsu_pkg::*;

    state_t                   state, next_state;
    logic                     lat_write;
    logic                     lat_unsigned;
    logic [1:0]               lat_size;
    logic [ADDRESS_WIDTH-1:0] lat_address;
    logic [31:0]              lat_wdata;
    logic [31:0]              lo_word;
    logic [1:0]               byte_count;
    logic [31:0]              aligned_data;
    logic [31:0]              align_lo;
    logic [23:0]              align_hi;
    logic [1:0]               offset;
    logic [ADDRESS_WIDTH-1:0] aligned_base;
    logic                     accept;

    assign offset       = lat_address[1:0];
    assign aligned_base = {lat_address[ADDRESS_WIDTH-1:2], 2'b00};
    assign req_ready    = (state == IDLE) && reset_n;
    assign accept       = req_valid && req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state       = state;
        mem_address      = '0;
        mem_write_enable = 2'b00;
        mem_write_value  = 32'd0;
        resp_valid       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = (req_size == SIZE_NONE) ? RESP : ACCESS_LO;
            end
            ACCESS_LO: begin
                if (lat_write) begin
                    mem_address = lat_address;
                    if (is_aligned(lat_size, offset)) begin
                        mem_write_enable = lat_size;
                        mem_write_value  = lat_wdata;
                        next_state       = RESP;
                    end else begin
                        next_state = STORE_BYTE;
                    end
                end else begin
                    mem_address = aligned_base;
                    next_state  = crosses_word(lat_size, offset) ? ACCESS_HI : RESP;
                end
            end
            ACCESS_HI: begin
                mem_address = aligned_base + ADDRESS_WIDTH'(4);
                next_state  = RESP;
            end
            STORE_BYTE: begin
                mem_address      = lat_address + ADDRESS_WIDTH'(byte_count);
                mem_write_enable = SIZE_BYTE;
                mem_write_value  = {24'd0, lat_wdata[{byte_count, 3'b000} +: 8]};
                if (byte_count == last_byte(lat_size)) next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // In ACCESS_LO the live read is the low word; in ACCESS_HI it is the high word.
    assign align_lo = (state == ACCESS_HI) ? lo_word : mem_read_value;
    assign align_hi = (state == ACCESS_HI) ? mem_read_value[23:0] : 24'd0;

    load_align u_load_align (
        .lo            (align_lo),
        .hi            (align_hi),
        .offset        (offset),
        .size          (lat_size),
        .unsigned_load (lat_unsigned),
        .data          (aligned_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'b00;
            lat_address  <= '0;
            lat_wdata    <= 32'd0;
            lo_word      <= 32'd0;
            byte_count   <= 2'd0;
            resp_rdata   <= 32'd0;
        end else begin
            if (accept) begin
                lat_write    <= req_write;
                lat_unsigned <= req_unsigned;
                lat_size     <= req_size;
                lat_address  <= req_address;
                lat_wdata    <= req_wdata;
                byte_count   <= 2'd0;
            end
            if (state == ACCESS_LO) lo_word <= mem_read_value;
            if (state == STORE_BYTE) byte_count <= byte_count + 2'd1;
            if (next_state == RESP && state != RESP) begin
                resp_rdata <= (!lat_write && (state == ACCESS_LO || state == ACCESS_HI))
                              ? aligned_data : 32'd0;
            end
        end
    end

endmodule
